parity_frame_rx: RTL and testbench

Serial receiver and checker for parity-protected frames. Takes an LSB-first bit stream of `DATA_W` data bits followed by one parity bit, delineated by a start-of-frame marker. Reassembles the data word, checks parity (even or odd), and presents word plus error flag on a valid/ready output. Sits at the far end of the parity-generation path, consuming the frames that the XOR-tree generators produce.

---
 rtl/parity_pkg.sv | 14 +
 rtl/parity_tree.sv | 11 +
 rtl/parity_frame_rx.sv | 166 ++++++++++++++++
 tb/tb_parity_frame_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the parity frame generator/receiver path.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    HOLD = 2'd3
  } prx_state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/parity_tree.sv
// Combinational XOR reduction of a W-bit vector; shared with the generator side.
module parity_tree #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_vec,
  output logic         o_par
);

  assign o_par = ^i_vec;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial LSB-first parity frame receiver: reassembles DATA_W bits, checks the
// trailing parity bit and holds the word on a valid/ready output.
//
// state | meaning
// IDLE  | waiting for a bit with in_sof; other bits dropped
// DATA  | collecting data bits 1..DATA_W-1
// PAR   | next accepted bit is the parity bit
// HOLD  | word presented, waiting for out_ready
module parity_frame_rx
  import parity_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ODD    = PAR_EVEN,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bit,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic              abort,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int                  CNT_BITS = $clog2(DATA_W + 1);
  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(DATA_W - 1);
  localparam logic                ODD_BIT  = (ODD != PAR_EVEN);

  prx_state_t          r_state;
  prx_state_t          w_state_nxt;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] w_cnt_nxt;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   w_data_nxt;
  logic [DATA_W-1:0]   r_out_data;
  logic [CNT_W-1:0]    r_err_cnt;
  logic [CNT_W-1:0]    w_err_cnt_nxt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_perr;
  logic                r_abort;
  logic                w_accept;
  logic                w_start;
  logic                w_restart;
  logic                w_par_take;
  logic                w_perr;
  logic                w_data_par;
  logic                w_deliver;

  parity_tree #(.W(DATA_W)) u_par (
    .i_vec (r_data),
    .o_par (w_data_par)
  );

  assign w_accept  = in_valid && r_in_ready;
  assign w_deliver = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept && in_sof) begin
          w_state_nxt = (DATA_W == 1) ? PAR : DATA;
        end
      end
      DATA: begin
        if (w_accept) begin
          if (in_sof) begin
            w_state_nxt = (DATA_W == 1) ? PAR : DATA;
          end else if (r_cnt == LAST_IDX) begin
            w_state_nxt = PAR;
          end
        end
      end
      PAR: begin
        if (w_accept) begin
          if (in_sof) begin
            w_state_nxt = (DATA_W == 1) ? PAR : DATA;
          end else begin
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_start    = w_accept && in_sof;
    w_restart  = w_start && ((r_state == DATA) || (r_state == PAR));
    w_par_take = w_accept && !in_sof && (r_state == PAR);
    w_perr     = (w_data_par ^ in_bit) != ODD_BIT;
    w_data_nxt = r_data;
    w_cnt_nxt  = r_cnt;
    // A new frame wipes the whole word so short-lived bits never leak across frames.
    if (w_start) begin
      w_data_nxt    = '0;
      w_data_nxt[0] = in_bit;
      w_cnt_nxt     = CNT_BITS'(1);
    end else if (w_accept && (r_state == DATA)) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (r_cnt == CNT_BITS'(i)) begin
          w_data_nxt[i] = in_bit;
        end
      end
      w_cnt_nxt = r_cnt + CNT_BITS'(1);
    end
    w_err_cnt_nxt = r_err_cnt;
    if (err_clr) begin
      w_err_cnt_nxt = '0;
    end else if (w_deliver && r_perr && (r_err_cnt != '1)) begin
      w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_perr      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_abort     <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_data      <= w_data_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_state_nxt != HOLD);
      r_out_valid <= (w_state_nxt == HOLD);
      r_abort     <= w_restart;
      r_err_cnt   <= w_err_cnt_nxt;
      if (w_par_take) begin
        r_out_data <= r_data;
        r_perr     <= w_perr;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_perr  = r_perr;
  assign abort     = r_abort;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench: even and odd receivers share one stimulus stream and are
// compared every cycle against a frame-level model built from bit queues.
module tb_parity_frame_rx;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_bit = 1'b0, in_sof = 1'b0, out_ready = 1'b0, err_clr = 1'b0;

  logic         rdy_e, vld_e, perr_e, abt_e;
  logic [W-1:0] dat_e;
  logic [7:0]   cnt_e;
  logic         rdy_o, vld_o, perr_o, abt_o;
  logic [W-1:0] dat_o;
  logic [7:0]   cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  parity_frame_rx #(.DATA_W(W), .ODD(0), .CNT_W(8)) u_dut_even (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_e),
    .in_bit(in_bit), .in_sof(in_sof), .out_valid(vld_e), .out_ready(out_ready),
    .out_data(dat_e), .out_perr(perr_e), .abort(abt_e), .err_clr(err_clr),
    .err_cnt(cnt_e)
  );

  parity_frame_rx #(.DATA_W(W), .ODD(1), .CNT_W(8)) u_dut_odd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o),
    .in_bit(in_bit), .in_sof(in_sof), .out_valid(vld_o), .out_ready(out_ready),
    .out_data(dat_o), .out_perr(perr_o), .abort(abt_o), .err_clr(err_clr),
    .err_cnt(cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: collect bits of the current frame, decide at W+1 bits.
  bit m_bits[$];
  bit m_in_frame, m_hold, m_abort, m_perr_e, m_perr_o;
  int m_data, m_cnt_e, m_cnt_o, m_ones;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_bits.delete();
      m_in_frame = 0; m_hold = 0; m_abort = 0;
      m_perr_e = 0; m_perr_o = 0;
      m_data = 0; m_cnt_e = 0; m_cnt_o = 0;
    end else begin
      m_abort = 0;
      if (m_hold) begin
        if (out_ready) begin
          if (m_perr_e && m_cnt_e < 255) m_cnt_e++;
          if (m_perr_o && m_cnt_o < 255) m_cnt_o++;
          m_hold = 0;
        end
      end else if (in_valid) begin
        if (in_sof) begin
          if (m_in_frame) m_abort = 1;
          m_bits.delete();
          m_bits.push_back(in_bit);
          m_in_frame = 1;
        end else if (m_in_frame) begin
          m_bits.push_back(in_bit);
        end
        if (m_in_frame && m_bits.size() == W + 1) begin
          m_data = 0;
          m_ones = 0;
          for (int i = 0; i < W; i++) m_data += int'(m_bits[i]) << i;
          foreach (m_bits[i]) m_ones += int'(m_bits[i]);
          m_perr_e = (m_ones % 2) != 0;
          m_perr_o = (m_ones % 2) != 1;
          m_hold = 1;
          m_in_frame = 0;
        end
      end
      if (err_clr) begin
        m_cnt_e = 0;
        m_cnt_o = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready_even", rdy_e, !m_hold);
      chk("in_ready_odd", rdy_o, !m_hold);
      chk("out_valid_even", vld_e, m_hold);
      chk("out_valid_odd", vld_o, m_hold);
      chk("abort_even", abt_e, m_abort);
      chk("abort_odd", abt_o, m_abort);
      chk("err_cnt_even", cnt_e, m_cnt_e);
      chk("err_cnt_odd", cnt_o, m_cnt_o);
      if (m_hold) begin
        chk("out_data_even", dat_e, m_data);
        chk("out_data_odd", dat_o, m_data);
        chk("out_perr_even", perr_e, m_perr_e);
        chk("out_perr_odd", perr_o, m_perr_o);
      end
    end
  end

  task automatic drv(input bit v, input bit b, input bit s, input bit r, input bit c);
    in_valid = v; in_bit = b; in_sof = s; out_ready = r; err_clr = c;
    @(negedge clk);
  endtask

  task automatic send_frame(input bit [3:0] d, input bit p, input bit r);
    drv(1, d[0], 1, r, 0);
    for (int i = 1; i < W; i++) drv(1, d[i], 0, r, 0);
    drv(1, p, 0, r, 0);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_in_ready"}, rdy_e, 1);
    chk({tag, "_out_valid"}, vld_e, 0);
    chk({tag, "_out_data"}, dat_e, 0);
    chk({tag, "_out_perr"}, perr_e, 0);
    chk({tag, "_abort"}, abt_e, 0);
    chk({tag, "_err_cnt"}, cnt_e, 0);
    chk({tag, "_out_valid_odd"}, vld_o, 0);
    chk({tag, "_err_cnt_odd"}, cnt_o, 0);
  endtask

  initial begin
    @(negedge clk);
    chk_rst("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // bits 1,0,1,1 parity 1: even ok, odd error
    send_frame(4'hD, 1, 1);
    chk("lit_valid_lat", vld_e, 1);
    chk("lit_data_D", dat_e, 13);
    chk("lit_perr_even_ok", perr_e, 0);
    chk("lit_perr_odd_bad", perr_o, 1);
    drv(0, 0, 0, 1, 0);
    chk("lit_cnt_even_0", cnt_e, 0);
    chk("lit_cnt_odd_1", cnt_o, 1);

    send_frame(4'hD, 0, 1);
    chk("lit_perr_even_bad", perr_e, 1);
    chk("lit_perr_odd_ok", perr_o, 0);
    drv(0, 0, 0, 1, 0);
    chk("lit_cnt_even_1", cnt_e, 1);

    // backpressure: held word, offered bits not consumed
    send_frame(4'hD, 1, 0);
    repeat (5) begin
      drv(1, 1, 1, 0, 0);
      chk("lit_hold_ready", rdy_e, 0);
      chk("lit_hold_data", dat_e, 13);
    end
    drv(0, 0, 0, 1, 0);
    chk("lit_release_valid", vld_e, 0);
    chk("lit_release_ready", rdy_e, 1);
    chk("lit_release_abort", abt_e, 0);

    // restart on the third bit, then fresh frame 0,1,1,0 parity 0
    drv(1, 1, 1, 1, 0);
    drv(1, 1, 0, 1, 0);
    drv(1, 0, 1, 1, 0);
    chk("lit_abort_pulse", abt_e, 1);
    drv(1, 1, 0, 1, 0);
    chk("lit_abort_once", abt_e, 0);
    drv(1, 1, 0, 1, 0);
    drv(1, 0, 0, 1, 0);
    drv(1, 0, 0, 1, 0);
    chk("lit_restart_valid", vld_e, 1);
    chk("lit_restart_data", dat_e, 6);
    chk("lit_restart_perr", perr_e, 0);
    drv(0, 0, 0, 1, 0);

    repeat (4) drv(1, 1, 0, 1, 0);
    chk("lit_idle_drop", vld_e, 0);

    // saturation and clear priority
    drv(0, 0, 0, 1, 1);
    repeat (260) begin
      send_frame(4'h1, 0, 1);
      drv(0, 0, 0, 1, 0);
    end
    chk("lit_sat_255", cnt_e, 255);
    chk("lit_sat_odd_0", cnt_o, 0);
    send_frame(4'h1, 0, 1);
    drv(0, 0, 0, 1, 1);
    chk("lit_clr_priority", cnt_e, 0);

    // async reset mid-DATA
    send_frame(4'hD, 0, 1);
    drv(0, 0, 0, 1, 0);
    chk("lit_pre_rst_cnt", cnt_e, 1);
    drv(1, 1, 1, 1, 0);
    drv(1, 0, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk_rst("rst_data");
    @(negedge clk);
    rst_n = 1'b1;

    // async reset in HOLD: pending error word not counted
    send_frame(4'hD, 0, 0);
    drv(0, 0, 0, 0, 0);
    chk("lit_pre_rst_hold", vld_e, 1);
    #2 rst_n = 1'b0;
    #1 chk_rst("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(4'hA, 0, 1);
    chk("lit_post_rst_data", dat_e, 10);
    chk("lit_post_rst_perr", perr_e, 0);
    drv(0, 0, 0, 1, 0);

    repeat (4000) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      s = m_in_frame ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
      drv(v, bit'($urandom_range(0, 1)), s, ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 63) == 0));
    end
    repeat (3) drv(0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
